dest_reg_scoreboard: RTL and testbench
======================================

// Module: dest_reg_scoreboard
// PURPOSE
//  Tracks in-flight writes per architectural register on the register-write side of
//  the pipeline. The ID stage reports each 5-bit destination it issues; the WB stage
//  reports each destination it retires. The block returns busy flags for the rs/rt
//  source registers, a stall request and an issue-ready flag.
//  It sits between the ID hazard logic and the WB write port.
// PARAMETERS
//  CNT_W     2   width of each per-register pending counter (max CNT_MAX = 2**CNT_W-1)
//  TOT_W     6   width of the total in-flight counter tot_pending
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  flush        in   1      synchronous clear of all pending state (branch/exception)
//  iss_valid    in   1      ID issues an instruction that writes iss_rd
//  iss_rd       in   5      destination register of the issuing instruction
//  iss_ready    out  1      1 = counter for iss_rd can accept the issue
//  wb_valid     in   1      WB retires a write to wb_rd
//  wb_rd        in   5      destination register being written back
//  rs_addr      in   5      source register A queried by ID
//  rt_addr      in   5      source register B queried by ID
//  rs_use       in   1      instruction in ID reads rs_addr
//  rt_use       in   1      instruction in ID reads rt_addr
//  rs_busy      out  1      rs_addr has an outstanding write
//  rt_busy      out  1      rt_addr has an outstanding write
//  stall        out  1      (rs_use&rs_busy)|(rt_use&rt_busy)|(iss_valid&~iss_ready)
//  tot_pending  out  TOT_W  total outstanding writes across all registers
//  err_underflow out 1      sticky: WB retired a register whose count was 0
// BEHAVIOUR
//  - State: cnt[1..31], each CNT_W bits. Register 0 is never tracked: cnt[0] reads as 0.
//    Issues and WBs to r0 are ignored (no count change, no error). iss_ready=1 for r0.
//  - Reset (rst_n=0, async): every cnt=0, tot_pending=0, err_underflow=0.
//    Outputs follow combinationally: busy=0, stall=0, iss_ready=1.
//  - Issue accept: iss_valid & iss_ready & (iss_rd!=0) increments cnt[iss_rd] at the next edge.
//  - iss_ready = (cnt[iss_rd] != CNT_MAX) | (wb_valid & wb_rd==iss_rd).
//    A same-cycle retire frees one slot. An issue with iss_ready=0 is dropped;
//    ID must hold the instruction while stall=1.
//  - Retire: wb_valid & (wb_rd!=0) decrements cnt[wb_rd] at the next edge.
//    If cnt[wb_rd]==0 and there is no same-cycle accepted issue to that register:
//    count stays 0 and err_underflow sets. It clears only on reset.
//  - Same register, same cycle, issue accepted plus retire: count unchanged.
//    tot_pending is also unchanged.
//  - Different registers, same cycle: both updates apply independently.
//  - tot_pending: +1 per accepted non-r0 issue, -1 per valid non-underflow retire.
//    It is the net of both in the same cycle.
//  - Busy, combinational, zero latency:
//    rs_busy = (cnt[rs_addr] != 0) & ~(wb_valid & wb_rd==rs_addr & cnt[rs_addr]==1).
//    The register file writes first half-cycle, so a final retire in the same cycle
//    clears busy. rt_busy is defined the same way. rs_addr/rt_addr==0 gives busy=0.
//  - The issue in the current cycle does not affect busy in the same cycle.
//    ID queries before its own issue.
//  - flush=1 at an edge: all cnt=0 and tot_pending=0. Issue and retire in that cycle
//    are discarded. err_underflow is kept.
//  - Reset mid-operation clears everything immediately, independent of clk.
// TESTING
//  1 Reset, then iss r5 -> cnt[5]=1, rs_addr=5 rs_use=1 -> rs_busy=1, stall=1,
//    tot_pending=1.
//  2 cnt[5]=1; wb r5 same cycle as query rs=5 -> rs_busy=0, stall=0;
//    next cycle cnt[5]=0, tot_pending=0.
//  3 Issue r7 three times (CNT_W=2) -> cnt[7]=3; 4th iss r7 -> iss_ready=0, stall=1, cnt stays 3.
//    Same with wb r7 -> iss_ready=1, cnt stays 3.
//  4 iss r9 and wb r9 same cycle with cnt[9]=1 -> cnt[9]=1, tot unchanged.
//    wb r12 with cnt[12]=0 -> err_underflow=1, cnt[12]=0.
//  5 iss r0 / wb r0 / rs_addr=0 -> no count change, rs_busy=0, no error.
//  6 Pending r3,r4,r4 then flush with iss r6 -> all cnt=0, tot=0, r6 not tracked.
//    rst_n low mid-cycle -> outputs drop before next edge.

Source files
------------

// File: rtl/dest_reg_scoreboard.sv
// Per-register in-flight write scoreboard between ID issue and WB retire.
// Provides zero-latency busy flags for rs/rt, issue back-pressure and a sticky underflow flag.
module dest_reg_scoreboard #(
    parameter int CNT_W = 2,
    parameter int TOT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             iss_valid,
    input  logic [4:0]       iss_rd,
    output logic             iss_ready,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    input  logic             rs_use,
    input  logic             rt_use,
    output logic             rs_busy,
    output logic             rt_busy,
    output logic             stall,
    output logic [TOT_W-1:0] tot_pending,
    output logic             err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [TOT_W-1:0] TOT_ONE  = TOT_W'(1);

    // Entry 0 is hard-wired to zero so r0 never reads as busy or full.
    logic [31:0][CNT_W-1:0] w_cnt;

    logic [CNT_W-1:0] w_iss_cnt;
    logic [CNT_W-1:0] w_wb_cnt;
    logic [CNT_W-1:0] w_rs_cnt;
    logic [CNT_W-1:0] w_rt_cnt;
    logic             w_wb_hits_iss;
    logic             w_iss_acc;
    logic             w_wb_en;
    logic             w_wb_same_acc;
    logic             w_underflow;
    logic             w_wb_eff;
    logic             w_rs_final_wb;
    logic             w_rt_final_wb;

    logic [TOT_W-1:0] r_tot;
    logic             r_err;

    assign w_cnt[0] = CNT_ZERO;

    assign w_iss_cnt = w_cnt[iss_rd];
    assign w_wb_cnt  = w_cnt[wb_rd];
    assign w_rs_cnt  = w_cnt[rs_addr];
    assign w_rt_cnt  = w_cnt[rt_addr];

    // A retire to the same register this cycle frees the slot the issue needs.
    assign w_wb_hits_iss = wb_valid & (wb_rd == iss_rd);
    assign iss_ready     = (w_iss_cnt != CNT_MAX) | w_wb_hits_iss;

    assign w_iss_acc     = iss_valid & iss_ready & (iss_rd != 5'd0);
    assign w_wb_en       = wb_valid & (wb_rd != 5'd0);
    assign w_wb_same_acc = w_iss_acc & (iss_rd == wb_rd);

    // A retire against an empty counter is only legal when an issue to it lands together.
    assign w_underflow = w_wb_en & (w_wb_cnt == CNT_ZERO) & ~w_wb_same_acc;
    assign w_wb_eff    = w_wb_en & ~w_underflow;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            logic             w_inc;
            logic             w_dec;

            assign w_inc = w_iss_acc & (iss_rd == 5'(gi));
            assign w_dec = w_wb_eff & (wb_rd == 5'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= CNT_ZERO;
                end else if (flush) begin
                    r_cnt <= CNT_ZERO;
                end else if (w_inc && !w_dec) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end else if (w_dec && !w_inc) begin
                    r_cnt <= r_cnt - CNT_ONE;
                end
            end

            assign w_cnt[gi] = r_cnt;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tot <= '0;
        end else if (flush) begin
            r_tot <= '0;
        end else begin
            case ({w_iss_acc, w_wb_eff})
                2'b10:   r_tot <= r_tot + TOT_ONE;
                2'b01:   r_tot <= r_tot - TOT_ONE;
                default: r_tot <= r_tot;
            endcase
        end
    end

    // Sticky error survives flush; a flushed retire is discarded and cannot raise it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_underflow && !flush) begin
            r_err <= 1'b1;
        end
    end

    // The register file writes in the first half-cycle, so a final retire clears busy now.
    assign w_rs_final_wb = wb_valid & (wb_rd == rs_addr) & (w_rs_cnt == CNT_ONE);
    assign w_rt_final_wb = wb_valid & (wb_rd == rt_addr) & (w_rt_cnt == CNT_ONE);

    assign rs_busy = (w_rs_cnt != CNT_ZERO) & ~w_rs_final_wb;
    assign rt_busy = (w_rt_cnt != CNT_ZERO) & ~w_rt_final_wb;

    assign stall = (rs_use & rs_busy) | (rt_use & rt_busy) | (iss_valid & ~iss_ready);

    assign tot_pending   = r_tot;
    assign err_underflow = r_err;

endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// Directed bench for dest_reg_scoreboard: one task per scenario, hand-computed expectations.
module tb_dest_reg_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       iss_valid;
    logic [4:0] iss_rd;
    logic       iss_ready;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic [4:0] rs_addr;
    logic [4:0] rt_addr;
    logic       rs_use;
    logic       rt_use;
    logic       rs_busy;
    logic       rt_busy;
    logic       stall;
    logic [5:0] tot_pending;
    logic       err_underflow;

    int n_tests = 0;
    int n_fail  = 0;

    dest_reg_scoreboard #(.CNT_W(2), .TOT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_use(rs_use), .rt_use(rt_use),
        .rs_busy(rs_busy), .rt_busy(rt_busy), .stall(stall),
        .tot_pending(tot_pending), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic idle();
        flush = 1'b0; iss_valid = 1'b0; iss_rd = 5'd0; wb_valid = 1'b0; wb_rd = 5'd0;
        rs_addr = 5'd0; rt_addr = 5'd0; rs_use = 1'b0; rt_use = 1'b0;
    endtask

    // One line per transaction, then advance to 1 ns after the next rising edge.
    task automatic tick();
        $display("[TB] t=%0t iss=%b/r%0d wb=%b/r%0d flush=%b tot=%0d err=%b",
                 $time, iss_valid, iss_rd, wb_valid, wb_rd, flush, tot_pending, err_underflow);
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(input logic [4:0] rd);
        iss_valid = 1'b1; iss_rd = rd;
        tick();
    endtask

    task automatic retire(input logic [4:0] rd);
        wb_valid = 1'b1; wb_rd = rd;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle();
        iss_rd = 5'd7; rs_addr = 5'd5; rs_use = 1'b1; rt_addr = 5'd6; rt_use = 1'b1;
        #3;
        n_tests++; if (tot_pending !== 6'd0) begin n_fail++; $display("FAIL rst_tot got %0d want 0", tot_pending); end
        n_tests++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", err_underflow); end
        n_tests++; if ({rs_busy, rt_busy, stall} !== 3'b000) begin n_fail++; $display("FAIL rst_busy_stall got %b want 000", {rs_busy, rt_busy, stall}); end
        n_tests++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL rst_iss_ready got %b want 1", iss_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1; idle();
        @(posedge clk); #1;
    endtask

    task automatic test_issue_busy();
        issue(5'd5);
        rs_addr = 5'd5; rs_use = 1'b1; rt_addr = 5'd6; rt_use = 1'b1;
        #1;
        n_tests++; if (rs_busy !== 1'b1) begin n_fail++; $display("FAIL t1_rs_busy got %b want 1", rs_busy); end
        n_tests++; if (rt_busy !== 1'b0) begin n_fail++; $display("FAIL t1_rt_busy got %b want 0", rt_busy); end
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL t1_stall got %b want 1", stall); end
        n_tests++; if (tot_pending !== 6'd1) begin n_fail++; $display("FAIL t1_tot got %0d want 1", tot_pending); end
    endtask

    task automatic test_wb_bypass();
        wb_valid = 1'b1; wb_rd = 5'd5; rs_addr = 5'd5; rs_use = 1'b1;
        #1;
        n_tests++; if (rs_busy !== 1'b0) begin n_fail++; $display("FAIL t2_rs_busy_bypass got %b want 0", rs_busy); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL t2_stall got %b want 0", stall); end
        tick();
        rs_addr = 5'd5; rs_use = 1'b1;
        #1;
        n_tests++; if (rs_busy !== 1'b0) begin n_fail++; $display("FAIL t2_rs_busy_after got %b want 0", rs_busy); end
        n_tests++; if (tot_pending !== 6'd0) begin n_fail++; $display("FAIL t2_tot got %0d want 0", tot_pending); end
    endtask

    task automatic test_saturate();
        issue(5'd7); issue(5'd7); issue(5'd7);
        #1;
        n_tests++; if (tot_pending !== 6'd3) begin n_fail++; $display("FAIL t3_tot3 got %0d want 3", tot_pending); end
        iss_valid = 1'b1; iss_rd = 5'd7;
        #1;
        n_tests++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL t3_full_ready got %b want 0", iss_ready); end
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL t3_full_stall got %b want 1", stall); end
        tick();
        #1;
        n_tests++; if (tot_pending !== 6'd3) begin n_fail++; $display("FAIL t3_drop_tot got %0d want 3", tot_pending); end
        iss_valid = 1'b1; iss_rd = 5'd7; wb_valid = 1'b1; wb_rd = 5'd7; rs_addr = 5'd7;
        #1;
        n_tests++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL t3_wb_ready got %b want 1", iss_ready); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL t3_wb_stall got %b want 0", stall); end
        n_tests++; if (rs_busy !== 1'b1) begin n_fail++; $display("FAIL t3_busy_cnt3 got %b want 1", rs_busy); end
        tick();
        iss_valid = 1'b1; iss_rd = 5'd7;
        #1;
        n_tests++; if (tot_pending !== 6'd3) begin n_fail++; $display("FAIL t3_swap_tot got %0d want 3", tot_pending); end
        n_tests++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL t3_still_full got %b want 0", iss_ready); end
        idle();
        retire(5'd7); retire(5'd7); retire(5'd7);
        rs_addr = 5'd7;
        #1;
        n_tests++; if (tot_pending !== 6'd0) begin n_fail++; $display("FAIL t3_drain_tot got %0d want 0", tot_pending); end
        n_tests++; if (rs_busy !== 1'b0) begin n_fail++; $display("FAIL t3_drain_busy got %b want 0", rs_busy); end
        n_tests++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL t3_err got %b want 0", err_underflow); end
    endtask

    task automatic test_r0();
        iss_valid = 1'b1; iss_rd = 5'd0; wb_valid = 1'b1; wb_rd = 5'd0;
        rs_addr = 5'd0; rs_use = 1'b1; rt_addr = 5'd0; rt_use = 1'b1;
        #1;
        n_tests++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL t5_ready got %b want 1", iss_ready); end
        n_tests++; if ({rs_busy, rt_busy, stall} !== 3'b000) begin n_fail++; $display("FAIL t5_busy_stall got %b want 000", {rs_busy, rt_busy, stall}); end
        tick();
        #1;
        n_tests++; if (tot_pending !== 6'd0) begin n_fail++; $display("FAIL t5_tot got %0d want 0", tot_pending); end
        n_tests++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL t5_err got %b want 0", err_underflow); end
    endtask

    task automatic test_same_cycle();
        iss_valid = 1'b1; iss_rd = 5'd14; wb_valid = 1'b1; wb_rd = 5'd14;
        tick();
        rs_addr = 5'd14;
        #1;
        n_tests++; if (tot_pending !== 6'd0) begin n_fail++; $display("FAIL t4_empty_pair_tot got %0d want 0", tot_pending); end
        n_tests++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL t4_empty_pair_err got %b want 0", err_underflow); end
        n_tests++; if (rs_busy !== 1'b0) begin n_fail++; $display("FAIL t4_empty_pair_busy got %b want 0", rs_busy); end
        idle();
        issue(5'd9);
        iss_valid = 1'b1; iss_rd = 5'd9; wb_valid = 1'b1; wb_rd = 5'd9;
        tick();
        rs_addr = 5'd9;
        #1;
        n_tests++; if (tot_pending !== 6'd1) begin n_fail++; $display("FAIL t4_pair_tot got %0d want 1", tot_pending); end
        n_tests++; if (rs_busy !== 1'b1) begin n_fail++; $display("FAIL t4_pair_busy got %b want 1", rs_busy); end
        idle();
        retire(5'd9);
        issue(5'd11);
        iss_valid = 1'b1; iss_rd = 5'd13; wb_valid = 1'b1; wb_rd = 5'd11;
        tick();
        rs_addr = 5'd11; rt_addr = 5'd13;
        #1;
        n_tests++; if (tot_pending !== 6'd1) begin n_fail++; $display("FAIL t4_diff_tot got %0d want 1", tot_pending); end
        n_tests++; if ({rs_busy, rt_busy} !== 2'b01) begin n_fail++; $display("FAIL t4_diff_busy got %b want 01", {rs_busy, rt_busy}); end
        idle();
        retire(5'd13);
        retire(5'd12);
        rs_addr = 5'd12;
        #1;
        n_tests++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL t4_underflow got %b want 1", err_underflow); end
        n_tests++; if (tot_pending !== 6'd0) begin n_fail++; $display("FAIL t4_uf_tot got %0d want 0", tot_pending); end
        n_tests++; if (rs_busy !== 1'b0) begin n_fail++; $display("FAIL t4_uf_busy got %b want 0", rs_busy); end
    endtask

    task automatic test_flush_reset();
        issue(5'd3); issue(5'd4); issue(5'd4);
        rs_addr = 5'd3; rt_addr = 5'd4;
        #1;
        n_tests++; if (tot_pending !== 6'd3) begin n_fail++; $display("FAIL t6_pre_tot got %0d want 3", tot_pending); end
        n_tests++; if ({rs_busy, rt_busy} !== 2'b11) begin n_fail++; $display("FAIL t6_pre_busy got %b want 11", {rs_busy, rt_busy}); end
        idle();
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd6;
        tick();
        rs_addr = 5'd3; rt_addr = 5'd4;
        #1;
        n_tests++; if (tot_pending !== 6'd0) begin n_fail++; $display("FAIL t6_flush_tot got %0d want 0", tot_pending); end
        n_tests++; if ({rs_busy, rt_busy} !== 2'b00) begin n_fail++; $display("FAIL t6_flush_busy got %b want 00", {rs_busy, rt_busy}); end
        n_tests++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL t6_flush_err_kept got %b want 1", err_underflow); end
        rs_addr = 5'd6;
        #1;
        n_tests++; if (rs_busy !== 1'b0) begin n_fail++; $display("FAIL t6_r6_busy got %b want 0", rs_busy); end
        idle();
        issue(5'd8);
        rs_addr = 5'd8;
        #1;
        n_tests++; if (tot_pending !== 6'd1) begin n_fail++; $display("FAIL t6_r8_tot got %0d want 1", tot_pending); end
        rst_n = 1'b0;
        #2;
        n_tests++; if (tot_pending !== 6'd0) begin n_fail++; $display("FAIL t6_async_tot got %0d want 0", tot_pending); end
        n_tests++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL t6_async_err got %b want 0", err_underflow); end
        n_tests++; if (rs_busy !== 1'b0) begin n_fail++; $display("FAIL t6_async_busy got %b want 0", rs_busy); end
        rst_n = 1'b1;
        idle();
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_issue_busy();
        idle();
        test_wb_bypass();
        idle();
        test_saturate();
        idle();
        test_r0();
        idle();
        test_same_cycle();
        idle();
        test_flush_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
